// File: rtl/btn_debounce_pkg.sv
// Shared constants and types for the pushbutton debouncer.
// Clock and debounce time set the default acceptance count.
package btn_debounce_pkg;

  localparam int unsigned SYS_CLK_HZ  = 100_000_000;
  localparam int unsigned DEBOUNCE_US = 10_000;

  localparam int N_BTN_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;

  function automatic int cycles_for_us(
    input int unsigned clk_hz,
    input int unsigned us
  );
    return int'((clk_hz / 1_000_000) * us);
  endfunction

  localparam int CNT_MAX_DEF =
    cycles_for_us(SYS_CLK_HZ, DEBOUNCE_US);

endpackage

// File: rtl/btn_debounce_if.sv
// Button bundle between the pins side and the debouncer.
// slave = debouncer, master = whoever drives the raw pins.
interface btn_debounce_if
  import btn_debounce_pkg::*;
#(
  parameter int N_BTN = N_BTN_DEF
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_db;
  logic [N_BTN-1:0] btn_rel;

  modport master (
    output btn_raw,
    input  btn_db,
    input  btn_rel
  );

  modport slave (
    input  btn_raw,
    output btn_db,
    output btn_rel
  );

endinterface

// File: rtl/btn_db_chan.sv
// One debounce channel: synchronizer, stability counter,
// registered debounced level and release pulse.
module btn_db_chan #(
  parameter int CNT_MAX     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  output logic btn_db_o,
  output logic btn_rel_o
);

  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   db_q;
  logic                   db_d;
  logic                   rel_q;
  logic                   rel_d;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw_i};
    cnt_d  = '0;
    db_d   = db_q;
    // any agreement clears the count, so glitches never accumulate
    if (sync != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rel_d = db_q & ~db_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rel_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rel_q  <= rel_d;
    end
  end

  assign btn_db_o  = db_q;
  assign btn_rel_o = rel_q;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel pushbutton debouncer; channels are independent.
// Outputs debounced levels and a one-cycle release pulse.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int N_BTN       = N_BTN_DEF,
  parameter int CNT_MAX     = CNT_MAX_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input logic           clk,
  input logic           rst,
  btn_debounce_if.slave bus
);

  logic [N_BTN-1:0] db;
  logic [N_BTN-1:0] rel;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_db_chan #(
      .CNT_MAX     (CNT_MAX),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .btn_raw_i (bus.btn_raw[i]),
      .btn_db_o  (db[i]),
      .btn_rel_o (rel[i])
    );
  end

  assign bus.btn_db  = db;
  assign bus.btn_rel = rel;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with CNT_MAX=8, SYNC_STAGES=2.
// Directed scenarios plus random bounce against a window model.
module tb_btn_debounce;

  localparam int NB = 4;
  localparam int CM = 8;
  localparam int SS = 2;

  logic clk;
  logic rst;

  int n_chk;
  int n_pass;

  btn_debounce_if #(.N_BTN(NB)) bus ();

  btn_debounce #(
    .N_BTN       (NB),
    .CNT_MAX     (CM),
    .SYNC_STAGES (SS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: raw reaches the sync point SS edges later; a level
  // is accepted once the last CM sync samples all disagree with it.
  logic [NB-1:0] rawq[$];
  logic [NB-1:0] syncq[$];
  logic [NB-1:0] m_db;
  logic [NB-1:0] m_rel;

  always @(posedge clk or posedge rst) begin
    logic [NB-1:0] s;
    logic [NB-1:0] nxt;
    bit all_diff;
    if (rst) begin
      rawq.delete();
      for (int k = 0; k < SS; k++) rawq.push_back('0);
      syncq.delete();
      m_db  = '0;
      m_rel = '0;
    end else begin
      s = rawq.pop_front();
      rawq.push_back(bus.btn_raw);
      syncq.push_back(s);
      if (syncq.size() > CM) void'(syncq.pop_front());
      nxt = m_db;
      for (int i = 0; i < NB; i++) begin
        all_diff = (syncq.size() == CM);
        foreach (syncq[j])
          if (syncq[j][i] == m_db[i]) all_diff = 0;
        if (all_diff) nxt[i] = ~m_db[i];
      end
      m_rel = m_db & ~nxt;
      m_db  = nxt;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.btn_raw = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.btn_raw = 4'b1111;
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus.btn_db !== 4'b0000 || bus.btn_rel !== 4'b0000)
      $display("FAIL reset_hold db=%b rel=%b want db=0000 rel=0000",
               bus.btn_db, bus.btn_rel);
    else n_pass++;
    bus.btn_raw = '0;
    rst = 1'b0;
  endtask

  task automatic test_accept();
    logic [NB-1:0] exp_db;
    do_reset();
    bus.btn_raw = 4'b0001;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      exp_db = (c >= 10) ? 4'b0001 : 4'b0000;
      n_chk++;
      if (bus.btn_db !== exp_db || bus.btn_rel !== 4'b0000)
        $display("FAIL accept c=%0d db=%b rel=%b want db=%b rel=0000",
                 c, bus.btn_db, bus.btn_rel, exp_db);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    logic b;
    logic prev;
    int rises;
    do_reset();
    rises = 0;
    prev  = 1'b0;
    for (int j = 0; j < 32; j++) begin
      b = (j < 3) || (j >= 6 && j < 9) || (j >= 12);
      bus.btn_raw = {2'b00, b, 1'b0};
      @(negedge clk);
      if (bus.btn_db[1] && !prev) rises++;
      prev = bus.btn_db[1];
      n_chk++;
      if (bus.btn_db[1] !== (j >= 21))
        $display("FAIL bounce j=%0d db1=%b want %b",
                 j, bus.btn_db[1], (j >= 21));
      else n_pass++;
    end
    n_chk++;
    if (rises != 1)
      $display("FAIL bounce_rises got %0d want 1", rises);
    else n_pass++;
  endtask

  task automatic test_short_pulse();
    logic e_db;
    logic e_rel;
    do_reset();
    for (int j = 0; j < 20; j++) begin
      bus.btn_raw = {1'b0, (j < 7), 2'b00};
      @(negedge clk);
      n_chk++;
      if (bus.btn_db !== 4'b0000 || bus.btn_rel !== 4'b0000)
        $display("FAIL short7 j=%0d db=%b rel=%b want 0000/0000",
                 j, bus.btn_db, bus.btn_rel);
      else n_pass++;
    end
    // exactly CM cycles is the shortest pulse that is accepted
    for (int j = 0; j < 24; j++) begin
      bus.btn_raw = {1'b0, (j < 8), 2'b00};
      @(negedge clk);
      e_db  = (j >= 9) && (j < 17);
      e_rel = (j == 17);
      n_chk++;
      if (bus.btn_db[2] !== e_db || bus.btn_rel[2] !== e_rel)
        $display("FAIL pulse8 j=%0d db2=%b rel2=%b want %b/%b",
                 j, bus.btn_db[2], bus.btn_rel[2], e_db, e_rel);
      else n_pass++;
    end
  endtask

  task automatic test_release();
    logic [NB-1:0] e_db;
    logic [NB-1:0] e_rel;
    do_reset();
    bus.btn_raw = 4'b1111;
    repeat (12) @(negedge clk);
    n_chk++;
    if (bus.btn_db !== 4'b1111)
      $display("FAIL release_pre db=%b want 1111", bus.btn_db);
    else n_pass++;
    bus.btn_raw = 4'b0000;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      e_db  = (j >= 9) ? 4'b0000 : 4'b1111;
      e_rel = (j == 9) ? 4'b1111 : 4'b0000;
      n_chk++;
      if (bus.btn_db !== e_db || bus.btn_rel !== e_rel)
        $display("FAIL release j=%0d db=%b rel=%b want %b/%b",
                 j, bus.btn_db, bus.btn_rel, e_db, e_rel);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [NB-1:0] e_db;
    do_reset();
    bus.btn_raw = 4'b0001;
    repeat (12) @(negedge clk);
    bus.btn_raw = 4'b1001;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus.btn_db !== 4'b0000 || bus.btn_rel !== 4'b0000)
      $display("FAIL reset_async db=%b rel=%b want 0000/0000",
               bus.btn_db, bus.btn_rel);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus.btn_rel !== 4'b0000)
      $display("FAIL reset_norel rel=%b want 0000", bus.btn_rel);
    else n_pass++;
    rst = 1'b0;
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      e_db = (j >= 9) ? 4'b1001 : 4'b0000;
      n_chk++;
      if (bus.btn_db !== e_db || bus.btn_rel !== 4'b0000)
        $display("FAIL reset_mid j=%0d db=%b rel=%b want %b/0000",
                 j, bus.btn_db, bus.btn_rel, e_db);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [NB-1:0] r;
    logic [NB-1:0] prev_rel;
    int odds;
    int bad;
    do_reset();
    r = '0;
    prev_rel = '0;
    bad = 0;
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) begin
        case ($urandom_range(3))
          0:       odds = 2;
          1:       odds = 5;
          2:       odds = 12;
          default: odds = 40;
        endcase
      end
      for (int i = 0; i < NB; i++)
        if ($urandom_range(odds - 1) == 0) r[i] = ~r[i];
      bus.btn_raw = r;
      @(negedge clk);
      n_chk++;
      if (bus.btn_db !== m_db || bus.btn_rel !== m_rel) begin
        bad++;
        if (bad <= 10)
          $display("FAIL random c=%0d db=%b rel=%b want %b/%b",
                   c, bus.btn_db, bus.btn_rel, m_db, m_rel);
      end else n_pass++;
      n_chk++;
      if ((prev_rel & bus.btn_rel) !== '0) begin
        bad++;
        if (bad <= 10)
          $display("FAIL rel_width c=%0d rel=%b prev=%b want no overlap",
                   c, bus.btn_rel, prev_rel);
      end else n_pass++;
      prev_rel = bus.btn_rel;
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst = 1'b1;
    bus.btn_raw = '0;
    test_reset();
    test_accept();
    test_bounce();
    test_short_pulse();
    test_release();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter N_BTN, default 4: number of button channels.
REQ-002 Parameter CNT_MAX, default 1000000: stable cycles required before accepting a level change (10 ms at 100 MHz).
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer flop depth; SHALL be at least 2.
REQ-004 clk  input  1  single clock; all state on posedge clk.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 btn_raw  input  N_BTN  raw, asynchronous, bouncing pushbutton pins; 1 = pressed.
REQ-007 btn_db  output  N_BTN  debounced level per channel, registered; feeds the existing one-cycle press-edge detector.
REQ-008 btn_rel  output  N_BTN  one-cycle pulse per channel on an accepted release (btn_db 1->0), registered.

Function
REQ-009 Each btn_raw bit SHALL pass through SYNC_STAGES flops; only the final stage (sync) SHALL be used downstream.
REQ-010 Channels SHALL be fully independent; no shared counter or arbitration.
REQ-011 Per channel, a counter of width $clog2(CNT_MAX+1) SHALL clear in any cycle where sync == btn_db.
REQ-012 When sync != btn_db, the counter SHALL increment by 1 each cycle.
REQ-013 When sync != btn_db and the counter equals CNT_MAX-1, the next edge SHALL load btn_db <= sync and clear the counter (acceptance).
REQ-014 Any single-cycle return of sync to btn_db before acceptance SHALL restart the count from 0; partial counts SHALL never accumulate across glitches.
REQ-015 Latency: a btn_raw level held stable SHALL appear on btn_db exactly SYNC_STAGES + CNT_MAX cycles after the first sampling edge.
REQ-016 A pulse shorter than CNT_MAX cycles at sync SHALL never change btn_db.
REQ-017 btn_rel[i] SHALL be 1 for exactly the one cycle in which btn_db[i] first shows 0 after being 1; otherwise 0.
REQ-018 No press pulse SHALL be generated here; press detection remains downstream.
REQ-019 The counter SHALL never wrap: it saturates at CNT_MAX-1 only transiently because acceptance clears it.
REQ-020 Simultaneous acceptances on several channels SHALL all take effect in the same cycle.

Reset
REQ-021 While rst=1, SHALL hold: synchronizer flops 0, counters 0, btn_db 0, btn_rel 0, taking effect asynchronously.
REQ-022 Reset asserted mid-count SHALL discard the partial count; no btn_rel pulse SHALL be generated by reset itself.
REQ-023 A button held pressed through reset release SHALL be accepted after SYNC_STAGES + CNT_MAX cycles, as in REQ-015.

Structure
REQ-024 One sub-module, btn_db_chan (synchronizer + counter + btn_db/btn_rel flops for one bit), SHALL be instantiated N_BTN times by a generate loop.
REQ-025 System clock frequency and the default debounce time SHALL live as constants in the shared project constants package; CNT_MAX default SHALL derive from them.
REQ-026 No combinational path from btn_raw to any output.

Verification (bench uses CNT_MAX=8, SYNC_STAGES=2)
REQ-027 Reset, then btn_raw=4'b0001 held -> btn_db=4'b0001 exactly 10 cycles after the first sampling edge; btn_rel stays 0.
REQ-028 btn_raw[1] bounces 1,0,1,0 (each 3 cycles), then 1 held -> btn_db[1] rises 10 cycles after the last 0->1 transition; exactly one rise.
REQ-029 btn_raw[2] held 1 for 7 cycles, then 0 -> btn_db[2] never changes.
REQ-030 With btn_db=4'b1111, btn_raw goes to 4'b0000 -> btn_db=4'b0000 after 10 cycles, and btn_rel=4'b1111 for exactly that one cycle.
REQ-031 rst pulsed while channel 3 counter is 5 with btn_raw[3]=1 held -> outputs 0 immediately; btn_db[3] rises 10 cycles after reset release; no btn_rel pulse.
REQ-032 Random bounce on all channels for 10k cycles -> every btn_db edge preceded by CNT_MAX stable sync cycles (assertion), btn_rel width always 1.
